uart_rx_cmd: RTL and testbench
==============================

Name: uart_rx_cmd

Overview:
- Serial receive front end of the analyzer's host link: deserialises 8N1 bytes from the host UART line and assembles them into SUMP commands.
- Short commands are one byte with bit 7 = 0. Long commands are one opcode byte with bit 7 = 1, followed by 4 argument bytes.
- Drives uart_tx's id/xon/xoff request inputs directly, and presents every decoded command (opcode + 32-bit argument) to the core control logic.

Parameters:
- FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 921_600, line rate in bit/s.
- BITLENGTH, FREQ/BAUD, clocks per bit; must be >= 4.
- CW, $clog2(BITLENGTH), bit-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- frame_err  out  1  one-cycle strobe, stop bit sampled low.
- id  out  1  one-cycle strobe, opcode 0x02 received.
- xon  out  1  one-cycle strobe, opcode 0x11 received.
- xoff  out  1  one-cycle strobe, opcode 0x13 received.
- execute  out  1  one-cycle strobe, a complete command is available.
- opcode  out  8  opcode of the last completed command.
- opdata  out  32  argument of the last completed long command.

Behaviour:
- Reset (rst low, asynchronous):
  - All strobes, rx_data, opcode and opdata go to 0.
  - Both synchroniser flops go to 1.
  - Both FSMs go to their IDLE state; the counter clears.
  - A reset mid-byte or mid-command discards the partial data; no strobe is issued.
- Input: uart_rx passes through a 2-flop synchroniser. The FSMs see only the synchronised value s.
- Bit timing: a down-counter is loaded with (BITLENGTH-1), and s is sampled when the counter reaches 0. Bit period is exactly BITLENGTH clocks.
- RX FSM states and transitions:
  - R_IDLE: when s = 0, load the counter with (BITLENGTH/2 - 1) and go to R_START.
  - R_START: at counter 0, if s = 0 go to R_DATA with bit index 0 and counter = BITLENGTH-1. If s = 1 (glitch), return to R_IDLE with no strobe.
  - R_DATA: at each counter 0, shift s into the byte LSB first. After the 8th bit go to R_STOP.
  - R_STOP, s = 1 at counter 0: rx_data <= byte, rx_valid = 1 for the next cycle, go to R_IDLE.
  - R_STOP, s = 0 at counter 0: frame_err = 1 for one cycle, go to R_BREAK. rx_data is unchanged.
  - R_BREAK: wait until s = 1, then go to R_IDLE. A held-low line (break) produces exactly one frame_err.
- Command FSM, C_IDLE, on rx_valid with byte b:
  - b[7] = 0: opcode <= b; execute pulses one cycle after rx_valid.
  - In that same cycle: id pulses if b = 0x02, xon if b = 0x11, xoff if b = 0x13. opdata is unchanged.
  - b[7] = 1: latch b as the pending opcode, clear the argument byte index, go to C_ARG.
- Command FSM, C_ARG, on rx_valid:
  - Argument bytes k = 0..3 load opdata[8k+7:8k] (little-endian); this is a shadow register.
  - After byte 3, opcode and opdata update together, execute pulses one cycle after that rx_valid, and the FSM returns to C_IDLE.
  - No id/xon/xoff strobe is issued for long commands.
- A frame_err while in C_ARG aborts the command: return to C_IDLE with no execute; opcode and opdata keep their old values.
- opcode and opdata are stable from one execute until the next.
- Strobes never overlap a second byte: minimum byte spacing is 10·BITLENGTH clocks.

Test Plan:
- FREQ=16, BAUD=1 (BITLENGTH=16). Send byte 0xA5 -> exactly one rx_valid with rx_data=0xA5; rx_valid occurs 9.5 bit times (±2 clocks) after the start edge.
- Send 0x02 -> rx_valid; one cycle later id=1 and execute=1 with opcode=0x02; xon and xoff stay 0. Repeat with 0x11 -> xon=1, and 0x13 -> xoff=1.
- Send 0xC0, 0x78, 0x56, 0x34, 0x12 -> a single execute after the 5th byte with opcode=0xC0 and opdata=0x12345678; no execute after bytes 1-4.
- Send 0x81, 0x01, then a byte with the stop bit forced low -> one frame_err and no execute. Then send 0x00 -> execute with opcode=0x00 and opdata unchanged.
- Pulse uart_rx low for 4 clocks -> no rx_valid or frame_err. Hold uart_rx low for 30 bit times -> exactly one frame_err and no rx_valid; the next valid byte is received correctly.
- Assert rst during the 3rd argument byte of a long command -> all outputs 0; a following short 0x13 yields xoff with opcode=0x13.

Source files
------------

// File: rtl/uart_rx_cmd_if.sv
// Host-link receive bundle: serial line in, decoded bytes and SUMP commands out.
// master = uart_rx_cmd (receiver/decoder), slave = line driver and command consumer.
interface uart_rx_cmd_if;
  logic        uart_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        id;
  logic        xon;
  logic        xoff;
  logic        execute;
  logic [7:0]  opcode;
  logic [31:0] opdata;

  modport master (
    input  uart_rx,
    output rx_data, rx_valid, frame_err, id, xon, xoff, execute, opcode, opdata
  );

  modport slave (
    output uart_rx,
    input  rx_data, rx_valid, frame_err, id, xon, xoff, execute, opcode, opdata
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with SUMP command assembly: short (1-byte) and long (opcode + 4 args)
// commands, plus id/xon/xoff request strobes for the transmitter.
module uart_rx_cmd #(
  parameter int unsigned FREQ      = 50_000_000,
  parameter int unsigned BAUD      = 921_600,
  parameter int unsigned BITLENGTH = FREQ / BAUD,
  parameter int unsigned CW        = $clog2(BITLENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cmd_if.master bus
);

  localparam logic [CW-1:0] FULL_BIT = CW'(BITLENGTH - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BITLENGTH / 2 - 1);

  if (BITLENGTH < 4) begin : g_bitlength_check
    $error("uart_rx_cmd: BITLENGTH must be >= 4");
  end

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic {C_IDLE, C_ARG} cmd_state_t;

  logic          s_meta, s;
  rx_state_t     rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    rx_data_r;
  logic          rx_valid_r, frame_err_r;

  cmd_state_t    cmd_state;
  logic [1:0]    arg_idx;
  logic [7:0]    pend_op;
  logic [23:0]   shadow;
  logic [7:0]    opcode_r;
  logic [31:0]   opdata_r;
  logic          execute_r, id_r, xon_r, xoff_r;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= bus.uart_rx;
      s      <= s_meta;
    end
  end

  // Bit-level receiver: start qualified at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!s) begin
            cnt      <= HALF_BIT;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!s) begin
            cnt      <= FULL_BIT;
            bit_idx  <= 3'd0;
            rx_state <= R_DATA;
          end else begin
            rx_state <= R_IDLE;
          end
        end
        R_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg <= {s, shreg[7:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) rx_state <= R_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end
        end
        R_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (s) begin
            rx_data_r  <= shreg;
            rx_valid_r <= 1'b1;
            rx_state   <= R_IDLE;
          end else begin
            frame_err_r <= 1'b1;
            rx_state    <= R_BREAK;
          end
        end
        R_BREAK: begin
          if (s) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Command assembly; arguments collect in a shadow so opcode/opdata change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_state <= C_IDLE;
      arg_idx   <= '0;
      pend_op   <= '0;
      shadow    <= '0;
      opcode_r  <= '0;
      opdata_r  <= '0;
      execute_r <= 1'b0;
      id_r      <= 1'b0;
      xon_r     <= 1'b0;
      xoff_r    <= 1'b0;
    end else begin
      execute_r <= 1'b0;
      id_r      <= 1'b0;
      xon_r     <= 1'b0;
      xoff_r    <= 1'b0;
      case (cmd_state)
        C_IDLE: begin
          if (rx_valid_r) begin
            if (!rx_data_r[7]) begin
              opcode_r  <= rx_data_r;
              execute_r <= 1'b1;
              id_r      <= (rx_data_r == 8'h02);
              xon_r     <= (rx_data_r == 8'h11);
              xoff_r    <= (rx_data_r == 8'h13);
            end else begin
              pend_op   <= rx_data_r;
              arg_idx   <= 2'd0;
              cmd_state <= C_ARG;
            end
          end
        end
        C_ARG: begin
          if (frame_err_r) begin
            cmd_state <= C_IDLE;
          end else if (rx_valid_r) begin
            case (arg_idx)
              2'd0: shadow[7:0]   <= rx_data_r;
              2'd1: shadow[15:8]  <= rx_data_r;
              2'd2: shadow[23:16] <= rx_data_r;
              default: begin
                opcode_r  <= pend_op;
                opdata_r  <= {rx_data_r, shadow};
                execute_r <= 1'b1;
                cmd_state <= C_IDLE;
              end
            endcase
            arg_idx <= arg_idx + 2'd1;
          end
        end
        default: cmd_state <= C_IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.id        = id_r;
  assign bus.xon       = xon_r;
  assign bus.xoff      = xoff_r;
  assign bus.execute   = execute_r;
  assign bus.opcode    = opcode_r;
  assign bus.opdata    = opdata_r;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd at 16 clocks/bit: short-command table, long commands,
// framing errors, glitch/break handling and mid-command reset.
module tb_uart_rx_cmd;

  localparam int unsigned BITLEN   = 16;
  localparam int unsigned SYNC_LAT = 2;   // synchroniser delay added to the 9.5-bit nominal

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cmd_if bus ();

  uart_rx_cmd #(.FREQ(16), .BAUD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: running counts plus the snapshot of the latest strobe of each kind.
  int n_valid = 0, n_ferr = 0, n_exec = 0, n_id = 0, n_xon = 0, n_xoff = 0;
  int valid_cyc = 0, exec_cyc = 0;
  logic [7:0]  last_rx = '0, ex_op = '0;
  logic [31:0] ex_data = '0;
  logic        ex_id = 1'b0, ex_xon = 1'b0, ex_xoff = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid)  begin n_valid++; valid_cyc = cyc; last_rx = bus.rx_data; end
    if (bus.frame_err) n_ferr++;
    if (bus.id)        n_id++;
    if (bus.xon)       n_xon++;
    if (bus.xoff)      n_xoff++;
    if (bus.execute) begin
      n_exec++; exec_cyc = cyc;
      ex_id = bus.id; ex_xon = bus.xon; ex_xoff = bus.xoff;
      ex_op = bus.opcode; ex_data = bus.opdata;
    end
  end

  int b_valid, b_ferr, b_exec, b_id, b_xon, b_xoff;
  int start_cyc = 0;

  task automatic snap();
    b_valid = n_valid; b_ferr = n_ferr; b_exec = n_exec;
    b_id = n_id; b_xon = n_xon; b_xoff = n_xoff;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame (stop level selectable) followed by two idle bit times.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    start_cyc   = cyc;
    repeat (BITLEN) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (BITLEN) @(negedge clk);
    end
    bus.uart_rx = stop;
    repeat (BITLEN) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * BITLEN) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       e_id;
    logic       e_xon;
    logic       e_xoff;
  } svec_t;

  svec_t       tbl [5];
  logic [31:0] exp_opdata;
  int          lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h02, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h11, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h13, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h12, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 1'b0, 1'b0, 1'b0};

    bus.uart_rx = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rx_data",  32'(bus.rx_data), 32'h0);
    chk("rst_strobes",  32'({bus.rx_valid, bus.frame_err, bus.id, bus.xon, bus.xoff, bus.execute}), 32'h0);
    chk("rst_opcode",   32'(bus.opcode), 32'h0);
    chk("rst_opdata",   bus.opdata, 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 0xA5 is a long opcode: check the byte and its latency, then complete the command.
    snap();
    send_byte(8'hA5, 1'b1);
    lat = valid_cyc - start_cyc;
    chk("a5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
    chk("a5_rx_data",   32'(last_rx), 32'hA5);
    chk("a5_latency_ok", 32'(lat >= 152 + SYNC_LAT - 2 && lat <= 152 + SYNC_LAT + 2), 32'd1);
    chk("a5_no_exec",   32'(n_exec - b_exec), 32'd0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    chk("a5_args_no_exec", 32'(n_exec - b_exec), 32'd0);
    send_byte(8'hDE, 1'b1);
    chk("a5_exec_cnt",  32'(n_exec - b_exec), 32'd1);
    chk("a5_opcode",    32'(ex_op), 32'hA5);
    chk("a5_opdata",    ex_data, 32'hDEADBEEF);
    chk("a5_no_req",    32'((n_id - b_id) + (n_xon - b_xon) + (n_xoff - b_xoff)), 32'd0);
    exp_opdata = 32'hDEADBEEF;

    for (int v = 0; v < 5; v++) begin
      snap();
      send_byte(tbl[v].b, 1'b1);
      chk($sformatf("sc%0d_valid_cnt", v), 32'(n_valid - b_valid), 32'd1);
      chk($sformatf("sc%0d_rx_data", v),   32'(last_rx), 32'(tbl[v].b));
      chk($sformatf("sc%0d_exec_cnt", v),  32'(n_exec - b_exec), 32'd1);
      chk($sformatf("sc%0d_exec_lag", v),  32'(exec_cyc - valid_cyc), 32'd1);
      chk($sformatf("sc%0d_req_flags", v), 32'({ex_id, ex_xon, ex_xoff}),
          32'({tbl[v].e_id, tbl[v].e_xon, tbl[v].e_xoff}));
      chk($sformatf("sc%0d_req_cnts", v),  32'({n_id - b_id, n_xon - b_xon, n_xoff - b_xoff} != 0 ?
          {2'(n_id - b_id), 2'(n_xon - b_xon), 2'(n_xoff - b_xoff)} : 6'd0),
          32'({1'b0, tbl[v].e_id, 1'b0, tbl[v].e_xon, 1'b0, tbl[v].e_xoff}));
      chk($sformatf("sc%0d_opcode", v),    32'(ex_op), 32'(tbl[v].b));
      chk($sformatf("sc%0d_opdata", v),    ex_data, exp_opdata);
    end

    // Long command with per-byte check that nothing executes early.
    snap();
    send_byte(8'hC0, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("c0_no_early_exec", 32'(n_exec - b_exec), 32'd0);
    chk("c0_opcode_held",   32'(bus.opcode), 32'h7F);
    send_byte(8'h12, 1'b1);
    chk("c0_exec_cnt", 32'(n_exec - b_exec), 32'd1);
    chk("c0_exec_lag", 32'(exec_cyc - valid_cyc), 32'd1);
    chk("c0_opcode",   32'(ex_op), 32'hC0);
    chk("c0_opdata",   ex_data, 32'h12345678);
    exp_opdata = 32'h12345678;

    // Framing error mid-command aborts it; a following short command still works.
    snap();
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    chk("fe_ferr_cnt",  32'(n_ferr - b_ferr), 32'd1);
    chk("fe_valid_cnt", 32'(n_valid - b_valid), 32'd2);
    chk("fe_no_exec",   32'(n_exec - b_exec), 32'd0);
    chk("fe_rx_data",   32'(bus.rx_data), 32'h01);
    chk("fe_opcode",    32'(bus.opcode), 32'hC0);
    chk("fe_opdata",    bus.opdata, exp_opdata);
    snap();
    send_byte(8'h00, 1'b1);
    chk("fe_next_exec",   32'(n_exec - b_exec), 32'd1);
    chk("fe_next_opcode", 32'(ex_op), 32'h00);
    chk("fe_next_opdata", ex_data, exp_opdata);

    // Short low glitch is rejected at the start-bit check.
    snap();
    @(negedge clk) bus.uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (3 * BITLEN) @(negedge clk);
    chk("glitch_strobes", 32'((n_valid - b_valid) + (n_ferr - b_ferr)), 32'd0);

    // Break: 30 bit times low gives exactly one frame error.
    snap();
    @(negedge clk) bus.uart_rx = 1'b0;
    repeat (30 * BITLEN) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (2 * BITLEN) @(negedge clk);
    chk("brk_ferr_cnt",  32'(n_ferr - b_ferr), 32'd1);
    chk("brk_valid_cnt", 32'(n_valid - b_valid), 32'd0);
    snap();
    send_byte(8'h11, 1'b1);
    chk("brk_next_data", 32'(last_rx), 32'h11);
    chk("brk_next_xon",  32'(n_xon - b_xon), 32'd1);

    // Reset during the third argument byte discards the command.
    snap();
    send_byte(8'hC5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    fork
      send_byte(8'h33, 1'b1);
    join_none
    repeat (80) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rx_data", 32'(bus.rx_data), 32'h0);
    chk("mid_rst_strobes", 32'({bus.rx_valid, bus.frame_err, bus.id, bus.xon, bus.xoff, bus.execute}), 32'h0);
    chk("mid_rst_opcode",  32'(bus.opcode), 32'h0);
    chk("mid_rst_opdata",  bus.opdata, 32'h0);
    wait fork;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_exec", 32'(n_exec - b_exec), 32'd0);
    snap();
    send_byte(8'h13, 1'b1);
    chk("post_rst_exec",   32'(n_exec - b_exec), 32'd1);
    chk("post_rst_xoff",   32'({ex_id, ex_xon, ex_xoff}), 32'b001);
    chk("post_rst_opcode", 32'(ex_op), 32'h13);
    chk("post_rst_opdata", ex_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
